// File: rtl/vx_barrier_table_pkg.sv
// Shared types and sizing helpers for the barrier arrival table.
// Optional watchdog build: define VX_BARRIER_TIMEOUT_EN.
package vx_barrier_table_pkg;

    function automatic int unsigned up_clog2(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned NUM_WARPS_DEF    = 4;
    localparam int unsigned NUM_BARRIERS_DEF = 4;
    localparam int unsigned NW_BITS_DEF      = up_clog2(NUM_WARPS_DEF);
    localparam int unsigned NB_BITS_DEF      = up_clog2(NUM_BARRIERS_DEF);

    typedef struct packed {
        logic [NB_BITS_DEF-1:0] id;
        logic [NW_BITS_DEF-1:0] size_m1;
    } gpu_barrier_t;

    typedef struct packed {
        gpu_barrier_t           bar;
        logic [NW_BITS_DEF-1:0] wid;
    } gpu_barrier_req_t;

    typedef struct packed {
        logic                     valid;
        logic [NB_BITS_DEF-1:0]   id;
        logic [NUM_WARPS_DEF-1:0] wmask;
        logic                     timeout;
    } gpu_barrier_rel_t;

endpackage

// File: rtl/vx_barrier_table_entry.sv
// One barrier entry: arrival accumulation, warp flush and optional idle watchdog.
// Watchdog counter is present only when VX_BARRIER_TIMEOUT_EN is defined.
module vx_barrier_entry #(
    parameter int unsigned NUM_WARPS = 4,
    parameter int unsigned NW_BITS   = 2
`ifdef VX_BARRIER_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 arr_valid,
    input  logic [NW_BITS-1:0]   arr_wid,
    input  logic [NW_BITS-1:0]   arr_size_m1,
    input  logic                 flush_valid,
    input  logic [NW_BITS-1:0]   flush_wid,
    input  logic                 to_clear,
    output logic                 valid,
    output logic [NUM_WARPS-1:0] wmask,
    output logic                 complete,
    output logic [NUM_WARPS-1:0] comp_wmask,
    output logic                 dup,
    output logic                 expired
);

    logic [NW_BITS-1:0]   count;
    logic [NW_BITS-1:0]   size_q;
    logic [NUM_WARPS-1:0] wid_bit;
    logic [NUM_WARPS-1:0] fl_bit;
    logic                 already;
    logic                 flush_hit;
    logic [NW_BITS-1:0]   size_eff;

    always_comb begin
        wid_bit          = '0;
        fl_bit           = '0;
        wid_bit[arr_wid] = 1'b1;
        fl_bit[flush_wid] = 1'b1;
    end

    // An idle entry takes its target size from the arriving request itself.
    assign already    = valid & |(wmask & wid_bit);
    assign flush_hit  = |(wmask & fl_bit);
    assign size_eff   = valid ? size_q : arr_size_m1;
    assign complete   = arr_valid & ~already & (count == size_eff);
    assign dup        = arr_valid & (already | (valid & (arr_size_m1 != size_q)));
    assign comp_wmask = wmask | wid_bit;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid  <= 1'b0;
            wmask  <= '0;
            count  <= '0;
            size_q <= '0;
        end else if (arr_valid) begin
            if (complete) begin
                valid  <= 1'b0;
                wmask  <= '0;
                count  <= '0;
                size_q <= '0;
            end else if (!already) begin
                valid <= 1'b1;
                wmask <= wmask | wid_bit;
                count <= count + NW_BITS'(1);
                if (!valid) size_q <= arr_size_m1;
            end
        end else if (flush_valid && flush_hit) begin
            if (count == NW_BITS'(1)) begin
                valid  <= 1'b0;
                wmask  <= '0;
                count  <= '0;
                size_q <= '0;
            end else begin
                wmask <= wmask & ~fl_bit;
                count <= count - NW_BITS'(1);
            end
        end else if (to_clear) begin
            valid  <= 1'b0;
            wmask  <= '0;
            count  <= '0;
            size_q <= '0;
        end
    end

`ifdef VX_BARRIER_TIMEOUT_EN
    localparam int unsigned   TW    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] timer;

    // Saturates at T_MAX so a losing expired entry keeps requesting.
    always_ff @(posedge clk) begin
        if (reset || to_clear || arr_valid || !valid) begin
            timer <= '0;
        end else if (timer != T_MAX) begin
            timer <= timer + TW'(1);
        end
    end

    assign expired = valid & (timer == T_MAX);
`else
    assign expired = 1'b0;
`endif

endmodule

// File: rtl/vx_barrier_table.sv
// Multi-barrier arrival table: id decode, release arbitration and registered outputs.
// Optional watchdog release: define VX_BARRIER_TIMEOUT_EN.
module vx_barrier_table
    import vx_barrier_table_pkg::*;
#(
    parameter int unsigned NUM_WARPS      = 4,
    parameter int unsigned NUM_BARRIERS   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    localparam int unsigned NW_BITS       = up_clog2(NUM_WARPS),
    localparam int unsigned NB_BITS       = up_clog2(NUM_BARRIERS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [NW_BITS-1:0]   req_wid,
    input  logic [NB_BITS-1:0]   req_id,
    input  logic [NW_BITS-1:0]   req_size_m1,
    input  logic                 flush_valid,
    input  logic [NW_BITS-1:0]   flush_wid,
    output logic                 rel_valid,
    output logic [NB_BITS-1:0]   rel_id,
    output logic [NUM_WARPS-1:0] rel_wmask,
    output logic                 rel_timeout,
    output logic [NUM_WARPS-1:0] stalled_wmask,
    output logic                 err_dup
);

    logic                                    accept;
    logic [NUM_BARRIERS-1:0]                 arr_hit;
    logic [NUM_BARRIERS-1:0]                 to_clear;
    logic [NUM_BARRIERS-1:0]                 ent_valid;
    logic [NUM_BARRIERS-1:0][NUM_WARPS-1:0]  ent_wmask;
    logic [NUM_BARRIERS-1:0]                 ent_complete;
    logic [NUM_BARRIERS-1:0][NUM_WARPS-1:0]  ent_comp_wmask;
    logic [NUM_BARRIERS-1:0]                 ent_dup;
    logic [NUM_BARRIERS-1:0]                 ent_expired;

    assign req_ready = ~flush_valid;
    assign accept    = req_valid & ~flush_valid;

    for (genvar g = 0; g < NUM_BARRIERS; g++) begin : g_entry
        assign arr_hit[g] = accept & (req_id == NB_BITS'(g));

        vx_barrier_entry #(
            .NUM_WARPS      (NUM_WARPS),
            .NW_BITS        (NW_BITS)
`ifdef VX_BARRIER_TIMEOUT_EN
            , .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
`endif
        ) u_entry (
            .clk         (clk),
            .reset       (reset),
            .arr_valid   (arr_hit[g]),
            .arr_wid     (req_wid),
            .arr_size_m1 (req_size_m1),
            .flush_valid (flush_valid),
            .flush_wid   (flush_wid),
            .to_clear    (to_clear[g]),
            .valid       (ent_valid[g]),
            .wmask       (ent_wmask[g]),
            .complete    (ent_complete[g]),
            .comp_wmask  (ent_comp_wmask[g]),
            .dup         (ent_dup[g]),
            .expired     (ent_expired[g])
        );
    end

    logic                 comp_any;
    logic [NUM_WARPS-1:0] comp_mask;
    logic                 dup_any;
    logic                 to_found;
    logic [NB_BITS-1:0]   to_idx;
    logic [NUM_WARPS-1:0] to_mask;
    logic [NUM_BARRIERS-1:0] to_sel;

    // Arrival completion beats the watchdog; among expired entries the lowest index wins.
    always_comb begin
        comp_any  = 1'b0;
        comp_mask = '0;
        dup_any   = 1'b0;
        to_found  = 1'b0;
        to_idx    = '0;
        to_mask   = '0;
        to_sel    = '0;
        for (int unsigned i = 0; i < NUM_BARRIERS; i++) begin
            comp_any  = comp_any | ent_complete[i];
            comp_mask = comp_mask | (ent_comp_wmask[i] & {NUM_WARPS{ent_complete[i]}});
            dup_any   = dup_any | ent_dup[i];
            if (!to_found && ent_expired[i] && !arr_hit[i] && !flush_valid) begin
                to_found  = 1'b1;
                to_idx    = NB_BITS'(i);
                to_mask   = ent_wmask[i];
                to_sel[i] = 1'b1;
            end
        end
        to_clear = comp_any ? '0 : to_sel;
    end

    always_comb begin
        stalled_wmask = '0;
        for (int unsigned i = 0; i < NUM_BARRIERS; i++) begin
            stalled_wmask = stalled_wmask | ent_wmask[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rel_valid   <= 1'b0;
            rel_id      <= '0;
            rel_wmask   <= '0;
            rel_timeout <= 1'b0;
            err_dup     <= 1'b0;
        end else begin
            rel_valid   <= comp_any | to_found;
            rel_id      <= comp_any ? req_id : to_idx;
            rel_wmask   <= comp_any ? comp_mask : to_mask;
            rel_timeout <= ~comp_any & to_found;
            err_dup     <= dup_any;
        end
    end

endmodule

// File: tb/tb_vx_barrier_table.sv
// Self-checking bench for vx_barrier_table: per-cycle behavioural model plus directed literal checks.
module tb_vx_barrier_table;

    localparam int unsigned NW = 4;
    localparam int unsigned NB = 4;
    localparam int unsigned TO = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_wid = '0;
    logic [1:0] req_id = '0;
    logic [1:0] req_size_m1 = '0;
    logic       flush_valid = 1'b0;
    logic [1:0] flush_wid = '0;
    logic       rel_valid;
    logic [1:0] rel_id;
    logic [3:0] rel_wmask;
    logic       rel_timeout;
    logic [3:0] stalled_wmask;
    logic       err_dup;

    int checks = 0;
    int errors = 0;

    vx_barrier_table #(
        .NUM_WARPS      (NW),
        .NUM_BARRIERS   (NB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_wid       (req_wid),
        .req_id        (req_id),
        .req_size_m1   (req_size_m1),
        .flush_valid   (flush_valid),
        .flush_wid     (flush_wid),
        .rel_valid     (rel_valid),
        .rel_id        (rel_id),
        .rel_wmask     (rel_wmask),
        .rel_timeout   (rel_timeout),
        .stalled_wmask (stalled_wmask),
        .err_dup       (err_dup)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: each barrier is a set of arrived warps plus its latched target size.
    bit         m_valid [NB];
    bit [3:0]   m_mask  [NB];
    bit [1:0]   m_size  [NB];
    int         m_age   [NB];
    logic       e_rel_valid = 1'b0;
    logic [1:0] e_rel_id = '0;
    logic [3:0] e_rel_wmask = '0;
    logic       e_rel_timeout = 1'b0;
    logic       e_err_dup = 1'b0;
    logic [3:0] e_stalled = '0;

    task automatic model_step();
        bit       comp;
        bit       exp_any;
        int       exp_idx;
        int       b;
        bit [3:0] wbit;
        int       need;
        e_rel_valid   = 1'b0;
        e_rel_id      = '0;
        e_rel_wmask   = '0;
        e_rel_timeout = 1'b0;
        e_err_dup     = 1'b0;
        comp          = 1'b0;
        exp_any       = 1'b0;
        exp_idx       = 0;
        if (reset) begin
            for (int i = 0; i < NB; i++) begin
                m_valid[i] = 1'b0; m_mask[i] = '0; m_size[i] = '0; m_age[i] = 0;
            end
        end else begin
`ifdef VX_BARRIER_TIMEOUT_EN
            for (int i = 0; i < NB; i++) begin
                if (!exp_any && m_valid[i] && m_age[i] >= TO - 1 && !flush_valid
                    && !(req_valid && 32'(req_id) == i)) begin
                    exp_any = 1'b1;
                    exp_idx = i;
                end
            end
`endif
            if (flush_valid) begin
                for (int i = 0; i < NB; i++) begin
                    m_mask[i][flush_wid] = 1'b0;
                    if (m_mask[i] == 4'b0000) m_valid[i] = 1'b0;
                end
            end else if (req_valid) begin
                b    = 32'(req_id);
                wbit = 4'b0001 << req_wid;
                if (m_valid[b] && (m_mask[b] & wbit) != 0) begin
                    e_err_dup = 1'b1;
                end else begin
                    if (m_valid[b] && m_size[b] != req_size_m1) e_err_dup = 1'b1;
                    need = m_valid[b] ? 32'(m_size[b]) : 32'(req_size_m1);
                    if ($countones(m_mask[b]) == need) begin
                        comp        = 1'b1;
                        e_rel_valid = 1'b1;
                        e_rel_id    = req_id;
                        e_rel_wmask = m_mask[b] | wbit;
                        m_valid[b]  = 1'b0;
                        m_mask[b]   = '0;
                    end else begin
                        if (!m_valid[b]) m_size[b] = req_size_m1;
                        m_valid[b] = 1'b1;
                        m_mask[b]  = m_mask[b] | wbit;
                    end
                end
            end
            if (!comp && exp_any) begin
                e_rel_valid     = 1'b1;
                e_rel_id        = 2'(exp_idx);
                e_rel_wmask     = m_mask[exp_idx];
                e_rel_timeout   = 1'b1;
                m_valid[exp_idx] = 1'b0;
                m_mask[exp_idx]  = '0;
            end
            for (int i = 0; i < NB; i++) begin
                if (!m_valid[i] || (req_valid && !flush_valid && 32'(req_id) == i)) m_age[i] = 0;
                else if (m_age[i] < TO - 1) m_age[i]++;
            end
        end
        e_stalled = '0;
        for (int i = 0; i < NB; i++) e_stalled = e_stalled | m_mask[i];
    endtask

    // Outputs reflect the previous edge; inputs seen here are the ones the next edge samples.
    always @(negedge clk) begin
        check("req_ready", 32'(req_ready), 32'(!flush_valid));
        check("rel_valid", 32'(rel_valid), 32'(e_rel_valid));
        if (e_rel_valid) begin
            check("rel_id", 32'(rel_id), 32'(e_rel_id));
            check("rel_wmask", 32'(rel_wmask), 32'(e_rel_wmask));
        end
        check("rel_timeout", 32'(rel_timeout), 32'(e_rel_timeout));
        check("err_dup", 32'(err_dup), 32'(e_err_dup));
        check("stalled_wmask", 32'(stalled_wmask), 32'(e_stalled));
        model_step();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arrive(input logic [1:0] w, input logic [1:0] id, input logic [1:0] sz);
        req_valid   = 1'b1;
        req_wid     = w;
        req_id      = id;
        req_size_m1 = sz;
        tick();
        req_valid   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout at %0t: got running expected finished", $time);
        $fatal(1);
    end

    initial begin
        tick();
        tick();
        check("reset_rel_valid", 32'(rel_valid), 32'(0));
        check("reset_stalled", 32'(stalled_wmask), 32'(0));
        reset = 1'b0;
        tick();

        // Four warps on id 1 back to back.
        arrive(0, 1, 3);
        arrive(1, 1, 3);
        arrive(2, 1, 3);
        check("t1_stalled_partial", 32'(stalled_wmask), 32'(4'b0111));
        arrive(3, 1, 3);
        check("t1_rel_valid", 32'(rel_valid), 32'(1));
        check("t1_rel_id", 32'(rel_id), 32'(1));
        check("t1_rel_wmask", 32'(rel_wmask), 32'(4'b1111));
        check("t1_stalled", 32'(stalled_wmask), 32'(0));
        tick();
        check("t1_pulse_end", 32'(rel_valid), 32'(0));

        // Single-warp barrier releases immediately.
        arrive(2, 0, 0);
        check("t2_rel_valid", 32'(rel_valid), 32'(1));
        check("t2_rel_id", 32'(rel_id), 32'(0));
        check("t2_rel_wmask", 32'(rel_wmask), 32'(4'b0100));
        check("t2_stalled", 32'(stalled_wmask), 32'(0));
        tick();

        // Duplicate arrival.
        arrive(1, 2, 1);
        arrive(1, 2, 1);
        check("t3_err_dup", 32'(err_dup), 32'(1));
        check("t3_stalled", 32'(stalled_wmask), 32'(4'b0010));
        check("t3_no_rel", 32'(rel_valid), 32'(0));
        arrive(3, 2, 1);
        check("t3_rel_wmask", 32'(rel_wmask), 32'(4'b1010));
        check("t3_err_clear", 32'(err_dup), 32'(0));

        // Size mismatch: flagged, latched size still governs completion.
        arrive(0, 0, 1);
        arrive(1, 0, 2);
        check("mm_err_dup", 32'(err_dup), 32'(1));
        check("mm_rel_wmask", 32'(rel_wmask), 32'(4'b0011));
        check("mm_rel_valid", 32'(rel_valid), 32'(1));

        // Flush collides with an arrival.
        arrive(0, 3, 2);
        arrive(1, 3, 2);
        flush_valid = 1'b1;
        flush_wid   = 2'd1;
        req_valid   = 1'b1;
        req_wid     = 2'd2;
        req_id      = 2'd3;
        req_size_m1 = 2'd2;
        #1;
        check("t4_req_ready", 32'(req_ready), 32'(0));
        tick();
        flush_valid = 1'b0;
        req_valid   = 1'b0;
        check("t4_after_flush", 32'(stalled_wmask), 32'(4'b0001));
        check("t4_flush_no_rel", 32'(rel_valid), 32'(0));
        arrive(2, 3, 2);
        check("t4_retry_no_rel", 32'(rel_valid), 32'(0));
        check("t4_stalled", 32'(stalled_wmask), 32'(4'b0101));
        arrive(3, 3, 2);
        check("t4_rel_wmask", 32'(rel_wmask), 32'(4'b1101));

        // Flush of the only warp idles the entry; a fresh size is latched next.
        arrive(1, 1, 3);
        flush_valid = 1'b1;
        flush_wid   = 2'd1;
        tick();
        flush_valid = 1'b0;
        check("fl_idle_stalled", 32'(stalled_wmask), 32'(0));
        arrive(0, 1, 0);
        check("fl_fresh_rel", 32'(rel_wmask), 32'(4'b0001));

        // Interleaved ids.
        arrive(0, 0, 1);
        arrive(0, 1, 1);
        arrive(1, 0, 1);
        check("il_rel_id0", 32'(rel_id), 32'(0));
        check("il_stalled", 32'(stalled_wmask), 32'(4'b0001));
        arrive(1, 1, 1);
        check("il_rel_id1", 32'(rel_id), 32'(1));
        check("il_rel_wmask1", 32'(rel_wmask), 32'(4'b0011));

        // Reset with partial entries.
        arrive(0, 0, 2);
        arrive(1, 1, 2);
        reset     = 1'b1;
        req_valid = 1'b1;
        req_wid   = 2'd2;
        req_id    = 2'd0;
        tick();
        reset     = 1'b0;
        req_valid = 1'b0;
        check("t6_stalled", 32'(stalled_wmask), 32'(0));
        check("t6_no_rel", 32'(rel_valid), 32'(0));
        arrive(3, 0, 0);
        check("t6_fresh_rel", 32'(rel_wmask), 32'(4'b1000));

`ifdef VX_BARRIER_TIMEOUT_EN
        begin
            int waited;
            bit seen;
            waited = 0;
            seen   = 1'b0;
            arrive(0, 1, 1);
            while (!seen && waited < 4 * TO) begin
                tick();
                waited++;
                if (rel_valid) seen = 1'b1;
            end
            check("t5_seen", 32'(seen), 32'(1));
            check("t5_wait", 32'(waited), 32'(TO));
            check("t5_timeout", 32'(rel_timeout), 32'(1));
            check("t5_rel_wmask", 32'(rel_wmask), 32'(4'b0001));
            check("t5_rel_id", 32'(rel_id), 32'(1));
        end
`endif

        // Partial barrier left alone; the model decides whether anything may fire.
        arrive(0, 2, 1);
        repeat (3 * TO) tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
